// File: rtl/maoin_button_pio.sv
// maoin_button_pio: debounced Avalon-MM input PIO with sticky edge capture and masked level irq
module maoin_button_pio #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [WIDTH-1:0] s1, s2, db, prev, irq_mask, edge_capture, ev, clr;
    logic wr;
    logic unused_wd;
    assign unused_wd = &{1'b0, writedata};
    assign wr  = chipselect & ~write_n;
    assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign ev  = (EDGE_TYPE == 0) ? (db & ~prev) : (EDGE_TYPE == 1) ? (~db & prev) : (db ^ prev);
    assign irq = |(edge_capture & irq_mask);
    always_comb begin
        readdata = '0;
        readdata[WIDTH-1:0] = (address == 2'd0) ? db : (address == 2'd2) ? irq_mask : (address == 2'd3) ? edge_capture : '0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1           <= '0;
            s2           <= '0;
            prev         <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            s1           <= in_port;
            s2           <= s1;
            prev         <= db;
            edge_capture <= ev | (edge_capture & ~clr);
            if (wr && address == 2'd2)
                irq_mask <= writedata[WIDTH-1:0];
        end
    end
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nofilt
            logic [WIDTH-1:0] db_r;
            assign db = db_r;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    db_r <= '0;
                else
                    db_r <= s2;
            end
        end else begin : g_filt
            // a bit flips only after N consecutive samples disagreeing with the accepted level
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                logic [CW-1:0] cnt;
                logic          q;
                assign db[i] = q;
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt <= '0;
                        q   <= 1'b0;
                    end else if (s2[i] == q) begin
                        cnt <= '0;
                    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                        q   <= s2[i];
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_maoin_button_pio.sv
// tb_maoin_button_pio: directed and random checks of falling-edge and any-edge instances
module tb_maoin_button_pio;
    localparam int N = 4;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect, write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd_f, rd_a;
    logic        irq_f, irq_a;
    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] m_s1, m_s2, m_db, m_prev, m_mask, m_cap_f, m_cap_a;
    logic [7:0] win [N];

    always #5 clk = ~clk;

    maoin_button_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(N), .EDGE_TYPE(1)) dut_f (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_f), .irq(irq_f));

    maoin_button_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(N), .EDGE_TYPE(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [1:0] a, input logic [7:0] cap);
        case (a)
            2'd0:    return {24'h0, m_db};
            2'd2:    return {24'h0, m_mask};
            2'd3:    return {24'h0, cap};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        {m_s1, m_s2, m_db, m_prev, m_mask, m_cap_f, m_cap_a} = '0;
        for (int k = 0; k < N; k++) win[k] = 8'h0;
    endtask

    // the accepted level flips where the last N synchronised samples all differ from it
    task automatic model_step();
        logic [7:0] clr, flip;
        if (!reset_n) begin
            model_reset();
            return;
        end
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h0;
        m_cap_f = (~m_db & m_prev) | (m_cap_f & ~clr);
        m_cap_a = (m_db ^ m_prev) | (m_cap_a & ~clr);
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[7:0];
        for (int k = N - 1; k > 0; k--) win[k] = win[k-1];
        win[0] = m_s2;
        flip = 8'hFF;
        for (int k = 0; k < N; k++) flip &= win[k] ^ m_db;
        m_prev = m_db;
        m_db   = m_db ^ flip;
        m_s2   = m_s1;
        m_s1   = in_port;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("rd_f", rd_f, mread(address, m_cap_f));
        check("rd_a", rd_a, mread(address, m_cap_a));
        check("irq_f", {31'h0, irq_f}, {31'h0, |(m_cap_f & m_mask)});
        check("irq_a", {31'h0, irq_a}, {31'h0, |(m_cap_a & m_mask)});
    endtask

    task automatic peek(input logic [1:0] a, input string tag, input logic [7:0] ef, input logic [7:0] ea);
        address = a;
        #1;
        check({tag, "_f"}, rd_f, {24'h0, ef});
        check({tag, "_a"}, rd_a, {24'h0, ea});
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; in_port = 8'hFF; address = 2'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
        model_reset();
        repeat (3) tick();
        peek(2'd0, "rst_data", 8'h00, 8'h00);
        peek(2'd2, "rst_mask", 8'h00, 8'h00);
        peek(2'd3, "rst_cap", 8'h00, 8'h00);
        check("rst_irq", {31'h0, irq_f}, 32'h0);
        address = 2'd0;
        reset_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check(e < 6 ? "db_pre" : "db_edge6", rd_f, e < 6 ? 32'h0 : 32'hFF);
        end
        repeat (2) tick();
        bus_write(2'd3, 32'hFF);
        peek(2'd3, "init_clr", 8'h00, 8'h00);
        in_port = 8'hFE;
        repeat (3) tick();
        in_port = 8'hFF;
        repeat (8) tick();
        peek(2'd0, "glitch_data", 8'hFF, 8'hFF);
        peek(2'd3, "glitch_cap", 8'h00, 8'h00);
        bus_write(2'd2, 32'h01);
        in_port = 8'hFE;
        repeat (5) tick();
        peek(2'd0, "press_pre", 8'hFF, 8'hFF);
        tick();
        peek(2'd0, "press_db", 8'hFE, 8'hFE);
        peek(2'd3, "press_cap0", 8'h00, 8'h00);
        tick();
        peek(2'd3, "press_cap", 8'h01, 8'h01);
        check("press_irq", {31'h0, irq_f}, 32'h1);
        tick();
        check("press_irq_hold", {31'h0, irq_f}, 32'h1);
        bus_write(2'd3, 32'h01);
        peek(2'd3, "clr_cap", 8'h00, 8'h00);
        check("clr_irq_f", {31'h0, irq_f}, 32'h0);
        check("clr_irq_a", {31'h0, irq_a}, 32'h0);
        in_port = 8'hFF;
        repeat (8) tick();
        peek(2'd3, "rel_cap", 8'h00, 8'h01);
        bus_write(2'd3, 32'h00);
        peek(2'd3, "w0_cap", 8'h00, 8'h01);
        bus_write(2'd3, 32'hFF);
        in_port = 8'hFD;
        repeat (6) tick();
        bus_write(2'd3, 32'h02);
        peek(2'd3, "clr_vs_ev", 8'h02, 8'h02);
        bus_write(2'd3, 32'h02);
        peek(2'd3, "clr_after", 8'h00, 8'h00);
        in_port = 8'hFF;
        repeat (8) tick();
        bus_write(2'd3, 32'hFF);
        bus_write(2'd2, 32'h00);
        in_port = 8'hF7;
        repeat (8) tick();
        peek(2'd3, "mask_cap", 8'h08, 8'h08);
        check("mask_irq_off", {31'h0, irq_f}, 32'h0);
        bus_write(2'd2, 32'h08);
        check("mask_irq_on", {31'h0, irq_f}, 32'h1);
        bus_write(2'd3, 32'hFF);
        in_port = 8'hF3;
        repeat (8) tick();
        peek(2'd3, "any_press", 8'h04, 8'h04);
        bus_write(2'd3, 32'hFF);
        in_port = 8'hF7;
        repeat (8) tick();
        peek(2'd3, "any_rel", 8'h00, 8'h04);
        bus_write(2'd3, 32'hFF);
        for (int c = 0; c < 800; c++) begin
            if (c == 400) begin
                #3 reset_n = 1'b0;
                model_reset();
                tick();
                tick();
                reset_n = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) in_port[3'($urandom_range(0, 7))] ^= 1'b1;
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            tick();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
